// File: rtl/mem_bus_unit_if.sv
// mem_bus_unit_if: request/response handshake plus memory-side beat bus.
// slave = the bus unit, master = its requester/memory environment.
interface mem_bus_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_wide;
  logic                  req_hipage;
  logic [ADDR_W-1:0]     req_addr;
  logic [2*DATA_W-1:0]   req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_rdata;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  req_valid, req_we, req_wide, req_hipage,
    input  req_addr, req_wdata, rsp_ready,
    input  mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_wide, req_hipage,
    output req_addr, req_wdata, rsp_ready,
    output mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: one/two-beat memory access sequencer with wait states.
// Optional MEM_BUS_UNIT_WRAP_CHECK_EN adds rsp_wrap (beat-1 address wrap flag).
module mem_bus_unit #(
  parameter int         ADDR_W      = 16,
  parameter int         DATA_W      = 8,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] HIGH_PAGE   = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_unit_if.slave bus
`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
  ,
  output logic          rsp_wrap
`endif
);

  typedef enum logic [1:0] {
    IDLE, BEAT0, BEAT1, RESP
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                wide_q, wide_d;
  logic                hip_q, hip_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_inc, req_addr_c;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                in_beat, done, accept;

  assign in_beat = (state_q == BEAT0) || (state_q == BEAT1);
  assign done    = in_beat && (cnt_q == WS) && bus.mem_ready;
  assign accept  = (state_q == IDLE) && bus.req_valid;

  assign req_addr_c = bus.req_hipage
    ? ADDR_W'({HIGH_PAGE, bus.req_addr[7:0]})
    : bus.req_addr;

  // High-page accesses stay inside their 256-byte page.
  always_comb begin
    addr_inc = addr_q + ADDR_W'(1);
    if (hip_q) begin
      addr_inc = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = BEAT0;
      BEAT0:   if (done) state_d = wide_q ? BEAT1 : RESP;
      BEAT1:   if (done) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    wide_d  = wide_q;
    hip_d   = hip_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (accept) begin
      we_d    = bus.req_we;
      wide_d  = bus.req_wide;
      hip_d   = bus.req_hipage;
      addr_d  = req_addr_c;
      wdata_d = bus.req_wdata;
      rdata_d = '0;
      cnt_d   = '0;
    end else if (in_beat) begin
      // Counter saturates at WS while waiting on mem_ready.
      if (done)              cnt_d = '0;
      else if (cnt_q != WS)  cnt_d = cnt_q + 4'd1;
      if (done && !we_q) begin
        if (state_q == BEAT0) rdata_d[DATA_W-1:0] = bus.mem_rdata;
        else rdata_d[2*DATA_W-1:DATA_W] = bus.mem_rdata;
      end
      if (done && (state_q == BEAT0) && wide_q) addr_d = addr_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      hip_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      wide_q  <= wide_d;
      hip_q   <= hip_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.mem_re    = in_beat && !we_q;
    bus.mem_we    = in_beat && we_q;
    bus.mem_addr  = in_beat ? addr_q : '0;
    bus.mem_wdata = '0;
    if (state_q == BEAT0) bus.mem_wdata = wdata_q[DATA_W-1:0];
    if (state_q == BEAT1) bus.mem_wdata = wdata_q[2*DATA_W-1:DATA_W];
  end

`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (accept) begin
      wrap_d = 1'b0;
    end else if ((state_q == BEAT0) && done && wide_q) begin
      wrap_d = hip_q ? (&addr_q[7:0]) : (&addr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign rsp_wrap = (state_q == RESP) && wrap_q;
`endif

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit: vector table + scoreboard for mem_bus_unit,
// plus stall, mid-beat reset and wait-state sequences.
module tb_mem_bus_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit hold2 = 1'b0;
  int sc2 = 0;

  mem_bus_unit_if #(.ADDR_W(16), .DATA_W(8)) b0 ();
  mem_bus_unit_if #(.ADDR_W(16), .DATA_W(8)) b2 ();

`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
  logic wrap0, wrap2;
`endif

  mem_bus_unit #(
    .ADDR_W(16), .DATA_W(8), .WAIT_STATES(0), .HIGH_PAGE(8'hFF)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
    , .rsp_wrap(wrap0)
`endif
  );

  mem_bus_unit #(
    .ADDR_W(16), .DATA_W(8), .WAIT_STATES(2), .HIGH_PAGE(8'hFF)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
    , .rsp_wrap(wrap2)
`endif
  );

  typedef struct {
    bit          we;
    bit          wide;
    bit          hip;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] a0;
    logic [15:0] a1;
    bit          wrap;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    bit          wrap;
    int          lat;
    int          nb;
    bit          we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  logic [24:0] bq[$];
  exp_t        me;
  logic [24:0] bt;

  logic [7:0] mem0 [0:65535];
  bit         wr0  [0:65535];

  function automatic logic [7:0] f(logic [15:0] a);
    if (a == 16'hC000) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h11;
  endfunction

  assign b0.mem_rdata = wr0[b0.mem_addr] ? mem0[b0.mem_addr] : f(b0.mem_addr);
  assign b0.mem_ready = 1'b1;

  always @(posedge clk) begin
    if (b0.mem_we) begin
      mem0[b0.mem_addr] <= b0.mem_wdata;
      wr0[b0.mem_addr]  <= 1'b1;
    end
  end

  always @(posedge clk) sc2 <= (b2.mem_re || b2.mem_we) ? sc2 + 1 : 0;
  assign b2.mem_ready = hold2 ? (sc2 >= 5) : 1'b1;
  assign b2.mem_rdata = b2.mem_ready ? 8'h6C : 8'hEE;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b0.req_valid && b0.req_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    if (b0.mem_re || b0.mem_we) begin
      if (b0.mem_re && b0.mem_we) check("strobe_excl", 1, 0);
      bq.push_back({b0.mem_we, b0.mem_addr, b0.mem_wdata});
    end
    if (rst && b0.rsp_valid && b0.rsp_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        me = sbq.pop_front();
        check("rsp_rdata", b0.rsp_rdata, me.rdata);
        if (me.lat != 0) check("latency", cyc - acc_cyc, me.lat);
`ifdef MEM_BUS_UNIT_WRAP_CHECK_EN
        check("rsp_wrap", wrap0, me.wrap);
`endif
        check("beat_count", bq.size(), me.nb);
        if (bq.size() >= 1) begin
          bt = bq[0];
          check("beat0_we", bt[24], me.we);
          check("beat0_addr", bt[23:8], me.a0);
          if (me.we) check("beat0_data", bt[7:0], me.wdata[7:0]);
        end
        if (bq.size() >= 2 && me.nb == 2) begin
          bt = bq[1];
          check("beat1_we", bt[24], me.we);
          check("beat1_addr", bt[23:8], me.a1);
          if (me.we) check("beat1_data", bt[7:0], me.wdata[15:8]);
        end
      end
      bq.delete();
    end
  end

  task automatic offer(vec_t v, int lat);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    b0.req_we    = v.we;
    b0.req_wide  = v.wide;
    b0.req_hipage = v.hip;
    b0.req_addr  = v.addr;
    b0.req_wdata = v.wdata;
    b0.req_valid = 1'b1;
    e.rdata = v.rdata;
    e.wrap  = v.wrap;
    e.lat   = lat;
    e.nb    = v.wide ? 2 : 1;
    e.we    = v.we;
    e.a0    = v.a0;
    e.a1    = v.a1;
    e.wdata = v.wdata;
    sbq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b0.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("rsp_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  task automatic run2(bit hold, output int strobes);
    bit got;
    hold2 = hold;
    @(posedge clk); #1;
    b2.req_we = 1'b0;
    b2.req_wide = 1'b0;
    b2.req_hipage = 1'b0;
    b2.req_addr = 16'h0042;
    b2.req_valid = 1'b1;
    @(negedge clk);
    check("d2_accept", b2.req_ready, 1);
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    strobes = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b2.mem_re) strobes++;
      if (b2.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("d2_rsp_timeout", 0, 1);
    check("d2_rdata", b2.rsp_rdata, 16'h006C);
    check("d2_addr_low", b2.mem_addr, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[11];
    int   st;
    bit   got;
    tv[0]  = '{0, 0, 0, 16'hC000, 16'h0000, 16'h005A, 16'hC000, 16'h0000, 0};
    tv[1]  = '{1, 1, 0, 16'h8000, 16'hBEEF, 16'h0000, 16'h8000, 16'h8001, 0};
    tv[2]  = '{0, 1, 0, 16'h8000, 16'h0000, 16'hBEEF, 16'h8000, 16'h8001, 0};
    tv[3]  = '{0, 1, 1, 16'h12FF, 16'h0000, 16'hEE11, 16'hFFFF, 16'hFF00, 1};
    tv[4]  = '{1, 0, 0, 16'h0000, 16'hAAA5, 16'h0000, 16'h0000, 16'h0000, 0};
    tv[5]  = '{0, 1, 0, 16'hFFFF, 16'h0000, 16'hA511, 16'hFFFF, 16'h0000, 1};
    tv[6]  = '{1, 0, 1, 16'h0034, 16'h5577, 16'h0000, 16'hFF34, 16'h0000, 0};
    tv[7]  = '{0, 0, 1, 16'h9934, 16'h0000, 16'h0077, 16'hFF34, 16'h0000, 0};
    tv[8]  = '{0, 1, 0, 16'h1230, 16'h0000, 16'h3233, 16'h1230, 16'h1231, 0};
    tv[9]  = '{1, 1, 1, 16'h0080, 16'h1234, 16'h0000, 16'hFF80, 16'hFF81, 0};
    tv[10] = '{0, 1, 0, 16'hFF80, 16'h0000, 16'h1234, 16'hFF80, 16'hFF81, 0};

    b0.req_valid = 0; b0.req_we = 0; b0.req_wide = 0; b0.req_hipage = 0;
    b0.req_addr = '0; b0.req_wdata = '0; b0.rsp_ready = 1;
    b2.req_valid = 0; b2.req_we = 0; b2.req_wide = 0; b2.req_hipage = 0;
    b2.req_addr = '0; b2.req_wdata = '0; b2.rsp_ready = 1;

    #2;
    check("rst_rsp_valid", b0.rsp_valid, 0);
    check("rst_mem_re", b0.mem_re, 0);
    check("rst_mem_we", b0.mem_we, 0);
    check("rst_mem_addr", b0.mem_addr, 0);
    check("rst_rdata", b0.rsp_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", b0.req_ready, 1);

    for (int i = 0; i < 11; i++) begin
      offer(tv[i], tv[i].wide ? 3 : 2);
      wait_done();
    end

    // Response back-pressure: output must hold while rsp_ready is low.
    @(posedge clk); #1;
    b0.rsp_ready = 1'b0;
    offer('{0, 0, 0, 16'h1230, 16'h0000, 16'h0033, 16'h1230, 16'h0000, 0}, 0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b0.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("stall_rsp_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", b0.rsp_valid, 1);
      check("stall_rdata", b0.rsp_rdata, 16'h0033);
      check("stall_req_ready", b0.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", b0.rsp_valid, 1);
    @(negedge clk);
    check("ready_after_rsp", b0.req_ready, 1);
    check("valid_after_rsp", b0.rsp_valid, 0);
    wait_done();

    // Reset while the second beat of a wide read is on the bus.
    @(posedge clk); #1;
    b0.req_we = 0; b0.req_wide = 1; b0.req_hipage = 0;
    b0.req_addr = 16'h4000; b0.req_valid = 1;
    @(negedge clk);
    check("mid_accept", b0.req_ready, 1);
    @(posedge clk); #1;
    b0.req_valid = 0;
    @(posedge clk); #1;
    check("mid_b1_re", b0.mem_re, 1);
    check("mid_b1_addr", b0.mem_addr, 16'h4001);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_re", b0.mem_re, 0);
    check("mid_rst_we", b0.mem_we, 0);
    check("mid_rst_addr", b0.mem_addr, 0);
    check("mid_rst_valid", b0.rsp_valid, 0);
    check("mid_rst_rdata", b0.rsp_rdata, 0);
    bq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", b0.req_ready, 1);
    repeat (4) @(negedge clk);
    check("mid_no_rsp", b0.rsp_valid, 0);
    bq.delete();

    // Wait states: memory stalls three extra cycles, then none.
    run2(1'b1, st);
    check("ws_held_strobes", st, 6);
    run2(1'b0, st);
    check("ws_min_strobes", st, 3);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_unit.md
MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width (legal range 9..32).
REQ-002 SHALL have parameter DATA_W, default 8, memory beat width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles each beat holds strobes (0..15).
REQ-004 SHALL have parameter HIGH_PAGE, default 8'hFF, upper address byte for high-page accesses.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, request offered.
REQ-008 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-009 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port req_wide, input, 1, 1 = two-beat access, 0 = one beat.
REQ-011 SHALL have port req_hipage, input, 1, 1 = address is {HIGH_PAGE, req_addr[7:0]}, zero-extended to ADDR_W.
REQ-012 SHALL have port req_addr, input, ADDR_W, start address.
REQ-013 SHALL have port req_wdata, input, 2*DATA_W, write data; low half is beat 0.
REQ-014 SHALL have port rsp_valid, output, 1, response available.
REQ-015 SHALL have port rsp_ready, input, 1, response consumed when high with rsp_valid.
REQ-016 SHALL have port rsp_rdata, output, 2*DATA_W, read data; high half zero for narrow reads.
REQ-017 SHALL have port mem_addr, output, ADDR_W, memory address.
REQ-018 SHALL have ports mem_re and mem_we, output, 1 each, memory strobes; never both high.
REQ-019 SHALL have port mem_wdata, output, DATA_W, memory write data.
REQ-020 SHALL have port mem_rdata, input, DATA_W, memory read data.
REQ-021 SHALL have port mem_ready, input, 1, memory beat-completion qualifier.

Function
REQ-022 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-023 SHALL assert req_ready only in IDLE; acceptance registers we, wide, computed address and wdata and moves to BEAT0 the next cycle.
REQ-024 SHALL drive mem_addr, mem_wdata and the selected strobe from registers in BEAT0/BEAT1 only; strobes low in IDLE and RESP.
REQ-025 SHALL complete a beat on the first cycle where the per-beat counter has reached WAIT_STATES and mem_ready=1; minimum beat length is WAIT_STATES+1 cycles.
REQ-026 SHALL capture mem_rdata into the matching half of rsp_rdata on the completing cycle of a read beat.
REQ-027 SHALL go from BEAT0 to BEAT1 if wide, else to RESP; from BEAT1 to RESP.
REQ-028 SHALL set beat-1 address to beat-0 address+1 modulo 2^ADDR_W; for hipage accesses only the low 8 bits increment (FF:FF wraps to FF:00).
REQ-029 SHALL hold rsp_valid high in RESP, and rsp_rdata stable, until rsp_ready; then return to IDLE, making req_ready high the next cycle.
REQ-030 SHALL issue responses for writes too (rsp_rdata = 0).
REQ-031 SHALL give a zero-wait narrow access latency of 2 cycles from acceptance to rsp_valid.

Reset
REQ-032 SHALL, on rst low, immediately (asynchronously) force IDLE, deassert mem_re, mem_we and rsp_valid, and clear mem_addr, mem_wdata, rsp_rdata and the beat counter to 0; req_ready SHALL be 1 from the first edge after release.
REQ-033 SHALL discard any in-flight access when reset occurs mid-beat; no response is produced for it.

Configuration
REQ-034 SHALL, with macro MEM_BUS_UNIT_WRAP_CHECK_EN defined, add output rsp_wrap, 1 bit, high with rsp_valid when a wide access's beat-1 address wrapped (REQ-028), cleared on reset.
REQ-035 SHALL, without MEM_BUS_UNIT_WRAP_CHECK_EN, omit port rsp_wrap and all related logic; wraparound behaviour itself is unchanged.

Verification
REQ-036 Narrow read, WAIT_STATES=0, mem_ready=1, addr 16'hC000, mem returns 8'h5A -> mem_re one cycle at C000, rsp_rdata=16'h005A two cycles after acceptance.
REQ-037 Wide write 16'hBEEF to 16'h8000 -> mem_we at 8000 with 8'hEF, then 8001 with 8'hBE, then rsp_valid.
REQ-038 Wide hipage read, req_addr[7:0]=8'hFF -> beats at FFFF then FF00; with WRAP_CHECK_EN rsp_wrap=1.
REQ-039 WAIT_STATES=2, mem_ready low 3 extra cycles on beat 0 -> strobe held 6 cycles; data captured only on completion.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready low throughout.
REQ-041 rst low mid-BEAT1 -> strobes drop immediately, no rsp_valid, req_ready=1 after release.
